// File: rtl/dmvm_score_pkg.sv
// Shared widths and helpers for the GAT attention-score datapath.
// Default widths live here so every GAT block agrees on product and sum sizes.
package dmvm_score_pkg;

  localparam int DATA_WIDTH_DEF      = 8;
  localparam int WH_DATA_WIDTH_DEF   = 12;
  localparam int DMVM_DATA_WIDTH_DEF = 19;
  localparam int NUM_FEATURE_OUT_DEF = 16;
  localparam int MAX_NODES_DEF       = 168;

  localparam int NUM_NODE_WIDTH = $clog2(MAX_NODES_DEF);
  localparam int PROD_WIDTH     = WH_DATA_WIDTH_DEF + DATA_WIDTH_DEF;
  localparam int SUM_WIDTH      = PROD_WIDTH + $clog2(NUM_FEATURE_OUT_DEF);

  // Clamp a signed value into the range of a signed field 'width' bits wide.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] val,
                                                  input int unsigned width);
    logic signed [63:0] maxV;
    logic signed [63:0] minV;
    maxV = (64'sd1 <<< (width - 1)) - 64'sd1;
    minV = -maxV - 64'sd1;
    if (val > maxV) return maxV;
    if (val < minV) return minV;
    return val;
  endfunction

endpackage

// File: rtl/dmvm_score_adder_tree.sv
// Registered binary adder tree: one pipeline stage per level, each level one bit wider.
// Holds every level when en_i is low so the whole datapath can freeze on back-pressure.
module adder_tree #(
  parameter int IN_WIDTH = 20,
  parameter int N        = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   en_i,
  input  logic [N*IN_WIDTH-1:0]                  data_i,
  output logic signed [IN_WIDTH+$clog2(N)-1:0]   sum_o
);

  localparam int LEVELS = $clog2(N);

  for (genvar lv = 0; lv < LEVELS; lv++) begin : g_lvl
    localparam int W   = IN_WIDTH + lv + 1;
    localparam int CNT = N >> (lv + 1);

    logic signed [W-2:0] in_w  [2*CNT];
    logic signed [W-1:0] sum_q [CNT];

    if (lv == 0) begin : g_src
      for (genvar k = 0; k < 2 * CNT; k++) begin : g_in
        assign in_w[k] = data_i[k*IN_WIDTH +: IN_WIDTH];
      end
    end else begin : g_src
      for (genvar k = 0; k < 2 * CNT; k++) begin : g_in
        assign in_w[k] = g_lvl[lv-1].sum_q[k];
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k < CNT; k++) sum_q[k] <= '0;
      end else if (en_i) begin
        for (int k = 0; k < CNT; k++)
          sum_q[k] <= {in_w[2*k][W-2], in_w[2*k]} + {in_w[2*k+1][W-2], in_w[2*k+1]};
      end
    end
  end

  assign sum_o = g_lvl[LEVELS-1].sum_q[0];

endmodule

// File: rtl/dmvm_score.sv
// Attention score unit: per node, dot products of a_src/a_dst with the WH row,
// pipelined through two adder trees and saturated, with subgraph framing tracking.
module dmvm_score
  import dmvm_score_pkg::*;
#(
  parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
  parameter int WH_DATA_WIDTH   = WH_DATA_WIDTH_DEF,
  parameter int DMVM_DATA_WIDTH = DMVM_DATA_WIDTH_DEF,
  parameter int NUM_FEATURE_OUT = NUM_FEATURE_OUT_DEF,
  parameter int MAX_NODES       = MAX_NODES_DEF
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [2*NUM_FEATURE_OUT*DATA_WIDTH-1:0]   a_flat_i,
  input  logic                                      a_rdy_i,
  input  logic                                      wh_vld_i,
  output logic                                      wh_rdy_o,
  input  logic [NUM_FEATURE_OUT*WH_DATA_WIDTH-1:0]  wh_data_i,
  input  logic [$clog2(MAX_NODES)-1:0]              wh_num_nodes_i,
  input  logic                                      wh_flag_i,
  output logic                                      score_vld_o,
  input  logic                                      score_rdy_i,
  output logic signed [DMVM_DATA_WIDTH-1:0]         score_src_o,
  output logic signed [DMVM_DATA_WIDTH-1:0]         score_dst_o,
  output logic                                      score_last_o,
  output logic                                      flag_err_o
);

  localparam int LEVELS = $clog2(NUM_FEATURE_OUT);
  localparam int NODE_W = $clog2(MAX_NODES);
  localparam int PROD_W = DATA_WIDTH + WH_DATA_WIDTH;
  localparam int SUM_W  = PROD_W + LEVELS;

  logic stall, advance, accept, isLast, errNow;
  logic [NODE_W-1:0] nodeIdx_d, nodeCnt_q;
  logic open_q, err_q;
  logic [LEVELS:0] vld_q, last_q;
  logic [NUM_FEATURE_OUT*PROD_W-1:0] prodSrc_d, prodDst_d, prodSrc_q, prodDst_q;
  logic signed [SUM_W-1:0] sumSrc, sumDst;
  logic scoreVld_q, scoreLast_q;
  logic signed [DMVM_DATA_WIDTH-1:0] scoreSrc_q, scoreDst_q;

  // A pending output that nobody takes freezes every stage, including input acceptance.
  assign stall    = scoreVld_q && !score_rdy_i;
  assign advance  = !stall;
  assign wh_rdy_o = !rst && a_rdy_i && !stall;
  assign accept   = wh_vld_i && wh_rdy_o;

  always_comb begin
    nodeIdx_d = wh_flag_i ? '0 : nodeCnt_q + NODE_W'(1);
    isLast    = (nodeIdx_d == wh_num_nodes_i - NODE_W'(1));
    errNow    = wh_flag_i ? open_q : !open_q;
  end

  // open_q marks a subgraph whose last node has not arrived yet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nodeCnt_q <= '0;
      open_q    <= 1'b0;
      err_q     <= 1'b0;
    end else if (accept) begin
      nodeCnt_q <= nodeIdx_d;
      open_q    <= !isLast;
      err_q     <= err_q | errNow;
    end
  end

  for (genvar k = 0; k < NUM_FEATURE_OUT; k++) begin : g_mul
    logic signed [PROD_W-1:0] aSrc, aDst, whElem;
    assign aSrc   = PROD_W'($signed(a_flat_i[k*DATA_WIDTH +: DATA_WIDTH]));
    assign aDst   = PROD_W'($signed(a_flat_i[(NUM_FEATURE_OUT+k)*DATA_WIDTH +: DATA_WIDTH]));
    assign whElem = PROD_W'($signed(wh_data_i[k*WH_DATA_WIDTH +: WH_DATA_WIDTH]));
    assign prodSrc_d[k*PROD_W +: PROD_W] = aSrc * whElem;
    assign prodDst_d[k*PROD_W +: PROD_W] = aDst * whElem;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q     <= '0;
      last_q    <= '0;
      prodSrc_q <= '0;
      prodDst_q <= '0;
    end else if (advance) begin
      vld_q     <= {vld_q[LEVELS-1:0], accept};
      last_q    <= {last_q[LEVELS-1:0], accept && isLast};
      prodSrc_q <= prodSrc_d;
      prodDst_q <= prodDst_d;
    end
  end

  adder_tree #(.IN_WIDTH(PROD_W), .N(NUM_FEATURE_OUT)) u_treeSrc (
    .clk(clk), .rst(rst), .en_i(advance), .data_i(prodSrc_q), .sum_o(sumSrc)
  );

  adder_tree #(.IN_WIDTH(PROD_W), .N(NUM_FEATURE_OUT)) u_treeDst (
    .clk(clk), .rst(rst), .en_i(advance), .data_i(prodDst_q), .sum_o(sumDst)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scoreVld_q  <= 1'b0;
      scoreLast_q <= 1'b0;
      scoreSrc_q  <= '0;
      scoreDst_q  <= '0;
    end else if (advance) begin
      scoreVld_q  <= vld_q[LEVELS];
      scoreLast_q <= last_q[LEVELS];
      scoreSrc_q  <= DMVM_DATA_WIDTH'(saturate(64'(sumSrc), DMVM_DATA_WIDTH));
      scoreDst_q  <= DMVM_DATA_WIDTH'(saturate(64'(sumDst), DMVM_DATA_WIDTH));
    end
  end

  assign score_vld_o  = scoreVld_q;
  assign score_last_o = scoreLast_q;
  assign score_src_o  = scoreSrc_q;
  assign score_dst_o  = scoreDst_q;
  assign flag_err_o   = err_q;

endmodule

// File: tb/tb_dmvm_score.sv
// Bench for dmvm_score: directed scenarios plus randomized framed traffic,
// scored against a dot-product reference model kept in a queue.
module tb_dmvm_score;

  localparam int NF = 16;
  localparam longint SAT_MAX = 262143;
  localparam longint SAT_MIN = -262144;

  typedef struct {
    longint src;
    longint dst;
    bit     last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [255:0] a_flat_i = '0;
  logic a_rdy_i = 1'b1;
  logic wh_vld_i = 1'b0;
  logic wh_rdy_o;
  logic [191:0] wh_data_i = '0;
  logic [7:0] wh_num_nodes_i = 8'd1;
  logic wh_flag_i = 1'b0;
  logic score_vld_o;
  logic score_rdy_i = 1'b1;
  logic signed [18:0] score_src_o;
  logic signed [18:0] score_dst_o;
  logic score_last_o;
  logic flag_err_o;

  int checks = 0;
  int errors = 0;
  int outCount = 0;
  bit randRdy = 1'b0;
  bit rdyForce = 1'b1;
  exp_t expQ[$];
  int mIdx = 0;
  bit mOpen = 1'b0;
  bit mErr = 1'b0;

  dmvm_score dut (
    .clk(clk), .rst(rst), .a_flat_i(a_flat_i), .a_rdy_i(a_rdy_i),
    .wh_vld_i(wh_vld_i), .wh_rdy_o(wh_rdy_o), .wh_data_i(wh_data_i),
    .wh_num_nodes_i(wh_num_nodes_i), .wh_flag_i(wh_flag_i),
    .score_vld_o(score_vld_o), .score_rdy_i(score_rdy_i),
    .score_src_o(score_src_o), .score_dst_o(score_dst_o),
    .score_last_o(score_last_o), .flag_err_o(flag_err_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
    end
  endtask

  function automatic longint satModel(input longint v);
    if (v > SAT_MAX) return SAT_MAX;
    if (v < SAT_MIN) return SAT_MIN;
    return v;
  endfunction

  function automatic longint dotModel(input logic [255:0] a, input logic [191:0] wh, input int half);
    longint s = 0;
    logic signed [7:0] ae;
    logic signed [11:0] we;
    for (int k = 0; k < NF; k++) begin
      ae = a[(half*NF + k)*8 +: 8];
      we = wh[k*12 +: 12];
      s += longint'(ae) * longint'(we);
    end
    return s;
  endfunction

  function automatic logic [191:0] fillWh(input int v);
    logic [191:0] r;
    for (int k = 0; k < NF; k++) r[k*12 +: 12] = 12'(v);
    return r;
  endfunction

  task automatic setA(input int srcV, input int dstV);
    for (int k = 0; k < NF; k++) begin
      a_flat_i[k*8 +: 8]      = 8'(srcV);
      a_flat_i[(NF+k)*8 +: 8] = 8'(dstV);
    end
  endtask

  // Ready driver: random back-pressure or a forced level from the directed code.
  always @(posedge clk) begin
    #2;
    score_rdy_i = randRdy ? ($urandom_range(0, 3) != 0) : rdyForce;
  end

  // Monitor/model: outputs are scored and words are modelled mid-cycle, before the handshake edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      expQ.delete();
      mIdx = 0;
      mOpen = 1'b0;
      mErr = 1'b0;
    end else begin
      if (score_vld_o && score_rdy_i) begin
        outCount++;
        checkOutput("outQueued", longint'(expQ.size() > 0), 1);
        if (expQ.size() > 0) begin
          e = expQ.pop_front();
          checkOutput("scoreSrc", score_src_o, e.src);
          checkOutput("scoreDst", score_dst_o, e.dst);
          checkOutput("scoreLast", score_last_o, e.last);
        end
        checkOutput("flagErr", flag_err_o, mErr);
      end
      if (wh_vld_i && wh_rdy_o) begin
        if (wh_flag_i) begin
          if (mOpen) mErr = 1'b1;
          mIdx = 0;
        end else begin
          if (!mOpen) mErr = 1'b1;
          mIdx++;
        end
        e.last = (mIdx == int'(wh_num_nodes_i) - 1);
        mOpen  = !e.last;
        e.src  = satModel(dotModel(a_flat_i, wh_data_i, 0));
        e.dst  = satModel(dotModel(a_flat_i, wh_data_i, 1));
        expQ.push_back(e);
      end
    end
  end

  // Presents a word and returns on the negedge before the edge that accepts it.
  task automatic applyStimulus(input bit flag, input int nn, input logic [191:0] wh);
    int n = 0;
    @(posedge clk); #2;
    a_rdy_i = 1'b1;
    wh_vld_i = 1'b1;
    wh_flag_i = flag;
    wh_num_nodes_i = 8'(nn);
    wh_data_i = wh;
    @(negedge clk);
    while (!wh_rdy_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!wh_rdy_o) checkOutput("acceptTimeout", wh_rdy_o, 1);
  endtask

  task automatic idleCycle();
    @(posedge clk); #2;
    wh_vld_i = 1'b0;
  endtask

  task automatic waitOutput(input string tag);
    int n = 0;
    @(negedge clk);
    while (!score_vld_o && n < 60) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, score_vld_o, 1);
  endtask

  task automatic waitDrain(input string tag);
    int n = 0;
    while (expQ.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, expQ.size(), 0);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int snap;
    int nn;
    #1 rst = 1'b1;
    #2;
    checkOutput("rstVld", score_vld_o, 0);
    checkOutput("rstLast", score_last_o, 0);
    checkOutput("rstSrc", score_src_o, 0);
    checkOutput("rstDst", score_dst_o, 0);
    checkOutput("rstWhRdy", wh_rdy_o, 0);
    checkOutput("rstErr", flag_err_o, 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // Basic dot product and latency.
    setA(1, 2);
    applyStimulus(1'b1, 1, fillWh(3));
    idleCycle();
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 5) checkOutput("lat5Vld", score_vld_o, 0);
    end
    checkOutput("lat6Vld", score_vld_o, 1);
    checkOutput("basicSrc", score_src_o, 48);
    checkOutput("basicDst", score_dst_o, 96);

    // Saturation in both directions.
    setA(127, 127);
    applyStimulus(1'b1, 1, fillWh(2047));
    idleCycle();
    waitOutput("satPosOut");
    checkOutput("satPosSrc", score_src_o, SAT_MAX);
    checkOutput("satPosDst", score_dst_o, SAT_MAX);
    setA(-128, -128);
    applyStimulus(1'b1, 1, fillWh(2047));
    idleCycle();
    waitOutput("satNegOut");
    checkOutput("satNegSrc", score_src_o, SAT_MIN);
    checkOutput("satNegDst", score_dst_o, SAT_MIN);

    // Three-node subgraph streamed back-to-back.
    setA(1, -1);
    applyStimulus(1'b1, 3, fillWh(5));
    applyStimulus(1'b0, 3, fillWh(-7));
    applyStimulus(1'b0, 3, fillWh(100));
    idleCycle();
    waitOutput("trioOut");
    checkOutput("trioLast0", score_last_o, 0);
    @(negedge clk);
    checkOutput("trioVld1", score_vld_o, 1);
    checkOutput("trioLast1", score_last_o, 0);
    @(negedge clk);
    checkOutput("trioVld2", score_vld_o, 1);
    checkOutput("trioLast2", score_last_o, 1);
    checkOutput("trioErr", flag_err_o, 0);

    // Five-word burst with four cycles of back-pressure.
    setA(3, -2);
    fork
      begin
        for (int j = 0; j < 5; j++) applyStimulus(j == 0, 5, fillWh(10 * j - 17));
        idleCycle();
      end
      begin
        waitOutput("burstOut");
        rdyForce = 1'b0;
        repeat (4) begin
          @(negedge clk);
          checkOutput("stallWhRdy", wh_rdy_o, 0);
          checkOutput("stallVldHeld", score_vld_o, 1);
        end
        rdyForce = 1'b1;
      end
    join
    waitDrain("burstDrain");

    // Randomized framed traffic with random back-pressure and input blocking.
    randRdy = 1'b1;
    repeat (25) begin
      idleCycle();
      a_flat_i = {8{$urandom}};
      nn = $urandom_range(1, 5);
      for (int j = 0; j < nn; j++) begin
        if ($urandom_range(0, 4) == 0) begin
          @(posedge clk); #2;
          a_rdy_i = 1'b0;
          wh_vld_i = 1'b1;
          wh_flag_i = 1'($urandom);
          wh_data_i = {6{$urandom}};
          @(negedge clk);
          checkOutput("aRdyBlock", wh_rdy_o, 0);
        end
        repeat ($urandom_range(0, 2)) idleCycle();
        applyStimulus(j == 0, nn, {6{$urandom}});
      end
    end
    idleCycle();
    randRdy = 1'b0;
    rdyForce = 1'b1;
    waitDrain("randDrain");
    checkOutput("randErr", flag_err_o, 0);

    // Framing error: new subgraph flag while the previous one is still open.
    snap = outCount;
    setA(2, 4);
    applyStimulus(1'b1, 2, fillWh(9));
    applyStimulus(1'b1, 2, fillWh(-9));
    idleCycle();
    waitDrain("errDrain");
    checkOutput("errRaised", flag_err_o, 1);
    checkOutput("errOutCount", outCount - snap, 2);
    repeat (5) @(negedge clk);
    checkOutput("errSticky", flag_err_o, 1);

    // Reset with three words in flight.
    setA(1, 1);
    applyStimulus(1'b1, 1, fillWh(50));
    applyStimulus(1'b1, 1, fillWh(60));
    applyStimulus(1'b1, 1, fillWh(70));
    idleCycle();
    rst = 1'b1;
    #1;
    checkOutput("midRstVld", score_vld_o, 0);
    checkOutput("midRstSrc", score_src_o, 0);
    checkOutput("midRstErr", flag_err_o, 0);
    @(negedge clk);
    checkOutput("midRstVldNext", score_vld_o, 0);
    checkOutput("midRstWhRdy", wh_rdy_o, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    snap = outCount;
    setA(3, 7);
    applyStimulus(1'b1, 1, fillWh(-2));
    idleCycle();
    waitOutput("postRstOut");
    checkOutput("postRstSrc", score_src_o, -96);
    checkOutput("postRstDst", score_dst_o, -224);
    waitDrain("postRstDrain");
    repeat (10) @(negedge clk);
    checkOutput("postRstCount", outCount - snap, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
